// File: rtl/usb_rx_packet_parser.sv
// USB receive packet parser: classifies byte stream by PID, checks
// CRC5/CRC16 and lengths, forwards payload bytes with CRC stripped.
module usb_rx_packet_parser #(
  parameter logic [6:0] DEV_ADDR    = 7'd0,
  parameter int         MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sop,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  input  logic       rx_eop,
  input  logic       rx_line_error,
  output logic [2:0] RX_Packet,
  output logic       rx_packet_valid,
  output logic [3:0] rx_endpoint,
  output logic [7:0] rx_data,
  output logic       store_rx_data,
  output logic       rx_busy
);
  localparam int CW = $clog2(MAX_PAYLOAD + 3);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PAYLOAD + 2);
  localparam logic [CW-1:0] CNT_CRC = CW'(2);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_PID     = 4'd1;
  localparam logic [3:0] S_TOKEN1  = 4'd2;
  localparam logic [3:0] S_TOKEN2  = 4'd3;
  localparam logic [3:0] S_TOK_END = 4'd4;
  localparam logic [3:0] S_DATA    = 4'd5;
  localparam logic [3:0] S_HS_END  = 4'd6;
  localparam logic [3:0] S_DISCARD = 4'd7;
  localparam logic [3:0] S_RESULT  = 4'd8;

  localparam logic [2:0] R_NONE  = 3'd0;
  localparam logic [2:0] R_IN    = 3'd1;
  localparam logic [2:0] R_OUT   = 3'd2;
  localparam logic [2:0] R_DATA0 = 3'd3;
  localparam logic [2:0] R_DATA1 = 3'd4;
  localparam logic [2:0] R_ACK   = 3'd5;
  localparam logic [2:0] R_NAK   = 3'd6;
  localparam logic [2:0] R_ERROR = 3'd7;

  function automatic logic [4:0] crc5_upd(
    input logic [4:0] c, input logic [7:0] b);
    logic [4:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ r[4];
      r  = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'h05;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_upd(
    input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ r[15];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return r;
  endfunction

  logic [3:0]    state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    h0_q, h0_d;
  logic [7:0]    h1_q, h1_d;
  logic [10:0]   tok_q, tok_d;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic [2:0]    pkt_q, pkt_d;
  logic          valid_q, valid_d;
  logic [3:0]    ep_q, ep_d;
  logic [7:0]    data_q, data_d;
  logic          store_q, store_d;
  logic          busy_q, busy_d;
  logic          fin;
  logic [2:0]    fin_code;
  logic          act;

  assign act = (state_q != S_IDLE) && (state_q != S_RESULT);

  // Next-state, result and payload pipeline decisions
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    tok_d    = tok_q;
    crc5_d   = crc5_q;
    crc16_d  = crc16_q;
    pkt_d    = pkt_q;
    ep_d     = ep_q;
    data_d   = data_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    store_d  = 1'b0;
    fin      = 1'b0;
    fin_code = R_ERROR;
    if (rx_sop) begin
      if (act) begin
        valid_d = 1'b1;
        pkt_d   = R_ERROR;
      end
      state_d = S_PID;
      busy_d  = 1'b1;
      res_d   = R_NONE;
      cnt_d   = '0;
      h0_d    = '0;
      h1_d    = '0;
      crc5_d  = 5'h1F;
      crc16_d = 16'hFFFF;
    end else if (act && rx_line_error) begin
      res_d = R_ERROR;
      if (rx_eop) fin = 1'b1;
      else state_d = S_DISCARD;
    end else begin
      unique case (state_q)
        S_IDLE, S_RESULT: state_d = S_IDLE;
        S_PID: begin
          if (rx_byte_valid) begin
            if (rx_byte[7:4] != ~rx_byte[3:0]) begin
              res_d   = R_ERROR;
              state_d = S_DISCARD;
            end else begin
              case (rx_byte)
                8'h69: begin code_d = R_IN;    state_d = S_TOKEN1; end
                8'hE1: begin code_d = R_OUT;   state_d = S_TOKEN1; end
                8'hC3: begin code_d = R_DATA0; state_d = S_DATA;   end
                8'h4B: begin code_d = R_DATA1; state_d = S_DATA;   end
                8'hD2: begin code_d = R_ACK;   state_d = S_HS_END; end
                8'h5A: begin code_d = R_NAK;   state_d = S_HS_END; end
                default: begin
                  res_d   = R_NONE;
                  state_d = S_DISCARD;
                end
              endcase
            end
          end else if (rx_eop) begin
            fin = 1'b1;
          end
        end
        S_TOKEN1: begin
          if (rx_byte_valid) begin
            tok_d[7:0] = rx_byte;
            crc5_d     = crc5_upd(crc5_q, rx_byte);
            state_d    = S_TOKEN2;
          end else if (rx_eop) begin
            fin = 1'b1;
          end
        end
        S_TOKEN2: begin
          if (rx_byte_valid) begin
            tok_d[10:8] = rx_byte[2:0];
            crc5_d      = crc5_upd(crc5_q, rx_byte);
            state_d     = S_TOK_END;
          end else if (rx_eop) begin
            fin = 1'b1;
          end
        end
        S_TOK_END: begin
          if (rx_byte_valid) begin
            res_d   = R_ERROR;
            state_d = S_DISCARD;
          end else if (rx_eop) begin
            fin = 1'b1;
            if (crc5_q != 5'b01100) begin
              fin_code = R_ERROR;
            end else if (tok_q[6:0] != DEV_ADDR) begin
              fin_code = R_NONE;
            end else begin
              fin_code = code_q;
              ep_d     = tok_q[10:7];
            end
          end
        end
        S_HS_END: begin
          if (rx_byte_valid) begin
            res_d   = R_ERROR;
            state_d = S_DISCARD;
          end else if (rx_eop) begin
            fin      = 1'b1;
            fin_code = code_q;
          end
        end
        S_DATA: begin
          if (rx_byte_valid) begin
            if (cnt_q == CNT_MAX) begin
              res_d   = R_ERROR;
              state_d = S_DISCARD;
            end else begin
              crc16_d = crc16_upd(crc16_q, rx_byte);
              cnt_d   = cnt_q + 1'b1;
              h0_d    = h1_q;
              h1_d    = rx_byte;
              if (cnt_q >= CNT_CRC) begin
                store_d = 1'b1;
                data_d  = h0_q;
              end
            end
          end else if (rx_eop) begin
            fin = 1'b1;
            if (cnt_q >= CNT_CRC && crc16_q == 16'h800D)
              fin_code = code_q;
          end
        end
        S_DISCARD: begin
          if (rx_eop) begin
            fin      = 1'b1;
            fin_code = res_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (fin) begin
      state_d = S_RESULT;
      valid_d = 1'b1;
      pkt_d   = fin_code;
      busy_d  = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= R_NONE;
      res_q   <= R_NONE;
      cnt_q   <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      tok_q   <= '0;
      crc5_q  <= '0;
      crc16_q <= '0;
      pkt_q   <= R_NONE;
      valid_q <= 1'b0;
      ep_q    <= '0;
      data_q  <= '0;
      store_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      tok_q   <= tok_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      ep_q    <= ep_d;
      data_q  <= data_d;
      store_q <= store_d;
      busy_q  <= busy_d;
    end
  end

  assign RX_Packet       = pkt_q;
  assign rx_packet_valid = valid_q;
  assign rx_endpoint     = ep_q;
  assign rx_data         = data_q;
  assign store_rx_data   = store_q;
  assign rx_busy         = busy_q;
endmodule

// File: tb/tb_usb_rx_packet_parser.sv
// Directed-vector bench for usb_rx_packet_parser.
// Bench builds its own CRC5/CRC16 trailers.
module tb_usb_rx_packet_parser;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_sop;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_eop;
  logic       rx_line_error;
  logic [2:0] RX_Packet, RX_Packet5;
  logic       rx_packet_valid, pv5;
  logic [3:0] rx_endpoint, ep5;
  logic [7:0] rx_data, rd5;
  logic       store_rx_data, st5;
  logic       rx_busy, busy5;

  always #5 clk = ~clk;

  usb_rx_packet_parser u_dut (
    .clk(clk), .rst(rst), .rx_sop(rx_sop), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .rx_eop(rx_eop),
    .rx_line_error(rx_line_error), .RX_Packet(RX_Packet),
    .rx_packet_valid(rx_packet_valid), .rx_endpoint(rx_endpoint),
    .rx_data(rx_data), .store_rx_data(store_rx_data), .rx_busy(rx_busy)
  );

  usb_rx_packet_parser #(.DEV_ADDR(7'd5)) u_dut5 (
    .clk(clk), .rst(rst), .rx_sop(rx_sop), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .rx_eop(rx_eop),
    .rx_line_error(rx_line_error), .RX_Packet(RX_Packet5),
    .rx_packet_valid(pv5), .rx_endpoint(ep5),
    .rx_data(rd5), .store_rx_data(st5), .rx_busy(busy5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int pulses5 = 0;
  logic [7:0] st_q[$];

  always @(negedge clk) begin
    if (rx_packet_valid) pulses <= pulses + 1;
    if (pv5) pulses5 <= pulses5 + 1;
    if (store_rx_data) st_q.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] b,
                       input logic e, input logic l);
    @(negedge clk);
    rx_sop = s; rx_byte_valid = v; rx_byte = b;
    rx_eop = e; rx_line_error = l;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pkt_body(input bq_t d);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    foreach (d[i]) drive(1'b0, 1'b1, d[i], 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic expect_result(input string tag, input logic [2:0] code);
    idle();
    check({tag, "_valid"}, rx_packet_valid, 1);
    check({tag, "_code"}, RX_Packet, code);
  endtask

  task automatic run_pkt(input string tag, input bq_t d,
                         input logic [2:0] code, input bq_t exp);
    int p0, s0;
    p0 = pulses;
    s0 = st_q.size();
    pkt_body(d);
    expect_result(tag, code);
    idle();
    idle();
    check({tag, "_pulses"}, pulses - p0, 1);
    check({tag, "_nstore"}, st_q.size() - s0, exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_st%0d", tag, i),
            (s0 + i < st_q.size()) ? {24'h0, st_q[s0 + i]} : 32'hDEAD,
            exp[i]);
  endtask

  function automatic bq_t with_crc16(input bq_t d);
    logic [15:0] c;
    logic fb;
    logic [7:0] b0, b1;
    bq_t r;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = d[i][k] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
      r.push_back(d[i]);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) begin
      b0[k] = c[15 - k];
      b1[k] = c[7 - k];
    end
    r.push_back(b0);
    r.push_back(b1);
    return r;
  endfunction

  function automatic bq_t token(input logic [7:0] pid,
                                input logic [6:0] addr,
                                input logic [3:0] ep);
    logic [10:0] f;
    logic [4:0] c;
    logic fb;
    bq_t r;
    f = {ep, addr};
    c = 5'h1F;
    for (int k = 0; k < 11; k++) begin
      fb = f[k] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    c = ~c;
    r.push_back(pid);
    r.push_back(f[7:0]);
    r.push_back({c[0], c[1], c[2], c[3], c[4], f[10:8]});
    return r;
  endfunction

  initial begin
    bq_t none, p3, e3, p65, e65;
    int p0, s0, q0;
    none = {};
    rst = 1'b1;
    rx_sop = 1'b0; rx_byte_valid = 1'b0; rx_byte = 8'h00;
    rx_eop = 1'b0; rx_line_error = 1'b0;
    idle();
    idle();
    check("rst_code", RX_Packet, 0);
    check("rst_valid", rx_packet_valid, 0);
    check("rst_store", store_rx_data, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ep", rx_endpoint, 0);
    rst = 1'b0;
    idle();

    run_pkt("ack", '{8'hD2}, 3'd5, none);
    run_pkt("nak", '{8'h5A}, 3'd6, none);
    run_pkt("hs_extra", '{8'hD2, 8'h00}, 3'd7, none);

    run_pkt("out_ep1", token(8'hE1, 7'd0, 4'd1), 3'd2, none);
    check("out_ep1_ep", rx_endpoint, 1);
    run_pkt("in_badcrc", '{8'h69, 8'h00, 8'h11}, 3'd7, none);
    check("in_badcrc_ep", rx_endpoint, 1);
    q0 = pulses5;
    run_pkt("in_ep0", '{8'h69, 8'h00, 8'h10}, 3'd1, none);
    check("in_ep0_ep", rx_endpoint, 0);
    check("addr5_code", RX_Packet5, 0);
    check("addr5_pulse", pulses5 - q0, 1);

    run_pkt("zlp_d1", '{8'h4B, 8'h00, 8'h00}, 3'd4, none);
    run_pkt("zlp_bad", '{8'hC3, 8'h00, 8'h01}, 3'd7, none);

    p3 = {8'h01, 8'h02, 8'h03};
    e3 = p3;
    p3 = with_crc16(p3);
    p3.push_front(8'hC3);
    run_pkt("data3", p3, 3'd3, e3);

    p65 = {};
    e65 = {};
    for (int i = 1; i <= 65; i++) begin
      p65.push_back(8'(i));
      if (i <= 64) e65.push_back(8'(i));
    end
    p65 = with_crc16(p65);
    p65.push_front(8'hC3);
    run_pkt("data65", p65, 3'd7, e65);

    run_pkt("setup_none", '{8'h2D, 8'h00, 8'h10}, 3'd0, none);
    run_pkt("bad_pid", '{8'hC4}, 3'd7, none);

    p0 = pulses;
    pkt_body('{8'hD2});
    expect_result("b2b_a", 3'd5);
    pkt_body('{8'h5A});
    expect_result("b2b_b", 3'd6);
    idle();
    idle();
    check("b2b_pulses", pulses - p0, 2);

    p0 = pulses;
    s0 = st_q.size();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    expect_result("line_err", 3'd7);
    idle();
    idle();
    check("line_err_pulses", pulses - p0, 1);
    check("line_err_nstore", st_q.size() - s0, 0);

    p0 = pulses;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hD2, 1'b0, 1'b0);
    check("sop_abort_valid", rx_packet_valid, 1);
    check("sop_abort_code", RX_Packet, 7);
    check("sop_abort_busy", rx_busy, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    expect_result("sop_restart", 3'd5);
    idle();
    idle();
    check("sop_restart_pulses", pulses - p0, 2);

    p0 = pulses;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    idle();
    idle();
    idle();
    check("mid_rst_pulses", pulses - p0, 0);
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_code", RX_Packet, 0);
    check("mid_rst_store", store_rx_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
